accel_spi_responder: RTL and testbench



---
 rtl/accel_spi_responder.sv | 203 ++++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_spi_responder.sv
// SPI mode-3 responder emulating the accelerometer register map, with a
// valid/ready sample port feeding a snapshot bank that is frozen during reads.
module accel_spi_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                spi_csn,
  input  logic                spi_sclk,
  input  logic                spi_sdi,
  output logic                spi_sdo,
  output logic                spi_sdo_oe,
  input  logic signed [15:0]  sample_x,
  input  logic signed [15:0]  sample_y,
  input  logic signed [15:0]  sample_z,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                data_ready_int,
  output logic                busy
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;

  state_t      state;
  logic        csn_p0, csn_p1, csn_p2;
  logic        sclk_p0, sclk_p1, sclk_p2;
  logic        sdi_p0, sdi_p1;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_in;
  logic [7:0]  tx_sh;
  logic [5:0]  addr;
  logic        mb;
  logic [7:0]  bw_rate, power_ctl, data_format;
  logic signed [DATA_W-1:0] bank_x, bank_y, bank_z;

  logic        csn_fall, csn_rise, sclk_rise, sclk_fall;
  logic [7:0]  cmd_byte;
  logic [5:0]  addr_next, rd_addr;
  logic [7:0]  rd_byte;
  logic        load_tx, dr_clr, sample_accept;

  // Stage p0/p1: two-flop synchronizers; p2 keeps history for edge detection.
  // CSN syncs reset low so a master already mid-transfer at reset release
  // cannot look like a fresh falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csn_p0  <= 1'b0;
      csn_p1  <= 1'b0;
      csn_p2  <= 1'b0;
      sclk_p0 <= 1'b1;
      sclk_p1 <= 1'b1;
      sclk_p2 <= 1'b1;
      sdi_p0  <= 1'b0;
      sdi_p1  <= 1'b0;
    end else begin
      csn_p0  <= spi_csn;
      csn_p1  <= csn_p0;
      csn_p2  <= csn_p1;
      sclk_p0 <= spi_sclk;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      sdi_p0  <= spi_sdi;
      sdi_p1  <= sdi_p0;
    end
  end

  assign csn_fall  = csn_p2 & ~csn_p1;
  assign csn_rise  = ~csn_p2 & csn_p1;
  assign sclk_rise = ~sclk_p2 & sclk_p1;
  assign sclk_fall = sclk_p2 & ~sclk_p1;

  assign cmd_byte      = {shift_in, sdi_p1};
  assign addr_next     = addr + {5'd0, mb};
  assign rd_addr       = (state == CMD) ? cmd_byte[5:0] : addr_next;
  assign load_tx       = sclk_rise && !csn_rise && (bit_cnt == 3'd7) &&
                         ((state == CMD && cmd_byte[7]) || state == RDATA);
  assign dr_clr        = load_tx && (rd_addr == 6'h32);
  assign sample_accept = sample_valid && sample_ready;

  always_comb begin
    rd_byte = 8'h00;
    case (rd_addr)
      6'h00:   rd_byte = DEVID;
      6'h2C:   rd_byte = bw_rate;
      6'h2D:   rd_byte = power_ctl;
      6'h30:   rd_byte = {data_ready_int, 7'b0};
      6'h31:   rd_byte = data_format;
      6'h32:   rd_byte = bank_x[7:0];
      6'h33:   rd_byte = bank_x[15:8];
      6'h34:   rd_byte = bank_y[7:0];
      6'h35:   rd_byte = bank_y[15:8];
      6'h36:   rd_byte = bank_z[7:0];
      6'h37:   rd_byte = bank_z[15:8];
      default: rd_byte = 8'h00;
    endcase
  end

  // Protocol FSM and writable registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift_in     <= 7'd0;
      tx_sh        <= 8'd0;
      addr         <= 6'd0;
      mb           <= 1'b0;
      spi_sdo      <= 1'b0;
      spi_sdo_oe   <= 1'b0;
      busy         <= 1'b0;
      sample_ready <= 1'b0;
      bw_rate      <= BW_RATE_RST;
      power_ctl    <= 8'd0;
      data_format  <= 8'd0;
    end else begin
      sample_ready <= (state == IDLE) && csn_p1;
      if (csn_rise && state != IDLE) begin
        // Any partial byte is simply dropped here.
        state      <= IDLE;
        bit_cnt    <= 3'd0;
        spi_sdo_oe <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csn_fall) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
              busy    <= 1'b1;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_in <= cmd_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                mb   <= cmd_byte[6];
                addr <= cmd_byte[5:0];
                if (cmd_byte[7]) begin
                  state      <= RDATA;
                  spi_sdo_oe <= 1'b1;
                  tx_sh      <= rd_byte;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (sclk_fall) begin
              spi_sdo <= tx_sh[7];
              tx_sh   <= {tx_sh[6:0], 1'b0};
            end else if (sclk_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                addr  <= addr_next;
                tx_sh <= rd_byte;
              end
            end
          end
          WDATA: begin
            if (sclk_rise) begin
              shift_in <= cmd_byte[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (addr)
                  6'h2C:   bw_rate     <= cmd_byte;
                  6'h2D:   power_ctl   <= cmd_byte;
                  6'h31:   data_format <= cmd_byte;
                  default: ;
                endcase
                addr <= addr_next;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sample bank: sample_ready is low whenever busy, so reads see a frozen bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_x         <= '0;
      bank_y         <= '0;
      bank_z         <= '0;
      data_ready_int <= 1'b0;
    end else begin
      if (sample_accept && power_ctl[3]) begin
        bank_x         <= sample_x;
        bank_y         <= sample_y;
        bank_z         <= sample_z;
        data_ready_int <= 1'b1;
      end else if (dr_clr) begin
        data_ready_int <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
// Bench for accel_spi_responder: a master model drives SPI and the sample
// port; a monitor assembles SDO bytes and compares them with queued values.
module tb_accel_spi_responder;

  localparam int H = 6;

  logic clk = 1'b0;
  logic reset_n, spi_csn, spi_sclk, spi_sdi, spi_sdo, spi_sdo_oe;
  logic signed [15:0] sample_x, sample_y, sample_z;
  logic sample_valid, sample_ready, data_ready_int, busy;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  accel_spi_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_csn        (spi_csn),
    .spi_sclk       (spi_sclk),
    .spi_sdi        (spi_sdi),
    .spi_sdo        (spi_sdo),
    .spi_sdo_oe     (spi_sdo_oe),
    .sample_x       (sample_x),
    .sample_y       (sample_y),
    .sample_z       (sample_z),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .data_ready_int (data_ready_int),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_byte(input string name, input logic [7:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Collects SDO on SCLK rising edges while the output is enabled.
  task automatic monitor();
    logic [7:0] sh;
    int n;
    exp_t e;
    sh = 8'd0;
    n  = 0;
    forever begin
      @(posedge spi_sclk or posedge spi_csn or negedge reset_n);
      if (spi_csn || !reset_n) begin
        n = 0;
      end else if (spi_sdo_oe) begin
        sh = {sh[6:0], spi_sdo};
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", sh);
          end else begin
            e = exp_q.pop_front();
            check(e.name, sh, e.val);
          end
        end
      end
    end
  endtask

  task automatic spi_bits(input logic [7:0] mosi, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_sclk = 1'b0;
      spi_sdi  = mosi[i];
      wait_clk(H);
      spi_sclk = 1'b1;
      wait_clk(H);
    end
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    spi_csn = 1'b1;
    wait_clk(H);
  endtask

  task automatic spi_write(input logic [5:0] a, input logic [7:0] d);
    cs_low();
    spi_bits({2'b00, a}, 8);
    spi_bits(d, 8);
    cs_high();
  endtask

  task automatic spi_read1(input string name, input logic [5:0] a, input logic [7:0] exp);
    expect_byte(name, exp);
    cs_low();
    spi_bits({2'b10, a}, 8);
    spi_bits(8'h00, 8);
    cs_high();
  endtask

  task automatic push_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int t;
    @(negedge clk);
    sample_x     = x;
    sample_y     = y;
    sample_z     = z;
    sample_valid = 1'b1;
    t = 0;
    while (!sample_ready && t < 100) begin
      wait_clk(1);
      t++;
    end
    if (t >= 100) begin
      checks++;
      $display("FAIL sample_ready_timeout: got 0, expected 1 within 100 cycles");
    end
    wait_clk(1);
    sample_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    reset_n      = 1'b0;
    spi_csn      = 1'b1;
    spi_sclk     = 1'b1;
    spi_sdi      = 1'b0;
    sample_valid = 1'b0;
    sample_x     = '0;
    sample_y     = '0;
    sample_z     = '0;
    fork
      monitor();
    join_none

    // Reset values
    wait_clk(3);
    check("rst_sdo", {7'd0, spi_sdo}, 8'd0);
    check("rst_sdo_oe", {7'd0, spi_sdo_oe}, 8'd0);
    check("rst_sample_ready", {7'd0, sample_ready}, 8'd0);
    check("rst_data_ready_int", {7'd0, data_ready_int}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    reset_n = 1'b1;
    wait_clk(4);
    check("idle_sample_ready", {7'd0, sample_ready}, 8'd1);

    // DEVID read with busy/oe timing
    expect_byte("devid", 8'hE5);
    spi_csn = 1'b0;
    wait_clk(2);
    check("busy_before_3cyc", {7'd0, busy}, 8'd0);
    wait_clk(1);
    check("busy_at_3cyc", {7'd0, busy}, 8'd1);
    check("ready_low_busy", {7'd0, sample_ready}, 8'd0);
    wait_clk(H - 3);
    spi_bits(8'h80, 8);
    check("oe_in_rdata", {7'd0, spi_sdo_oe}, 8'd1);
    spi_bits(8'h00, 8);
    spi_csn = 1'b1;
    wait_clk(2);
    check("oe_before_3cyc", {7'd0, spi_sdo_oe}, 8'd1);
    wait_clk(1);
    check("oe_after_3cyc", {7'd0, spi_sdo_oe}, 8'd0);
    check("busy_after_rise", {7'd0, busy}, 8'd0);
    check("ready_same_cyc", {7'd0, sample_ready}, 8'd0);
    wait_clk(1);
    check("ready_next_cyc", {7'd0, sample_ready}, 8'd1);
    wait_clk(H);

    // Writes and read-only protection
    spi_read1("bw_rate_rst", 6'h2C, 8'h0A);
    spi_write(6'h2D, 8'h08);
    spi_read1("power_ctl", 6'h2D, 8'h08);
    spi_write(6'h00, 8'h55);
    spi_read1("devid_ro", 6'h00, 8'hE5);
    spi_write(6'h33, 8'h77);
    spi_read1("bank_ro", 6'h33, 8'h00);

    // Sample accept and multi-byte read
    push_sample(16'hFF38, 16'h0012, 16'h00B4);
    check("dri_set", {7'd0, data_ready_int}, 8'd1);
    spi_read1("int_source_set", 6'h30, 8'h80);
    check("dri_kept_by_0x30", {7'd0, data_ready_int}, 8'd1);
    expect_byte("burst_x_lo", 8'h38);
    expect_byte("burst_x_hi", 8'hFF);
    expect_byte("burst_y_lo", 8'h12);
    expect_byte("burst_y_hi", 8'h00);
    expect_byte("burst_z_lo", 8'hB4);
    expect_byte("burst_z_hi", 8'h00);
    cs_low();
    spi_bits(8'hF2, 8);
    check("dri_cleared", {7'd0, data_ready_int}, 8'd0);
    for (int i = 0; i < 6; i++) spi_bits(8'h00, 8);
    cs_high();
    spi_read1("int_source_clr", 6'h30, 8'h00);

    // Coherency: new triple offered during a burst
    expect_byte("coh_x_lo", 8'h38);
    expect_byte("coh_x_hi", 8'hFF);
    expect_byte("coh_y_lo", 8'h12);
    expect_byte("coh_y_hi", 8'h00);
    expect_byte("coh_z_lo", 8'hB4);
    expect_byte("coh_z_hi", 8'h00);
    cs_low();
    sample_x     = 16'h1234;
    sample_y     = 16'h5678;
    sample_z     = 16'h9ABC;
    sample_valid = 1'b1;
    spi_bits(8'hF2, 8);
    for (int i = 0; i < 6; i++) begin
      spi_bits(8'h00, 8);
      check("coh_ready_low", {7'd0, sample_ready}, 8'd0);
    end
    spi_csn = 1'b1;
    t = 0;
    while (!sample_ready && t < 100) begin
      wait_clk(1);
      t++;
    end
    check("coh_ready_returns", {7'd0, sample_ready}, 8'd1);
    wait_clk(1);
    sample_valid = 1'b0;
    check("coh_dri_set", {7'd0, data_ready_int}, 8'd1);
    wait_clk(H);
    expect_byte("new_x_lo", 8'h34);
    expect_byte("new_x_hi", 8'h12);
    expect_byte("new_y_lo", 8'h78);
    expect_byte("new_y_hi", 8'h56);
    expect_byte("new_z_lo", 8'hBC);
    expect_byte("new_z_hi", 8'h9A);
    cs_low();
    spi_bits(8'hF2, 8);
    for (int i = 0; i < 6; i++) spi_bits(8'h00, 8);
    cs_high();

    // Abort a partial write, then address wrap
    spi_write(6'h31, 8'h0B);
    spi_read1("data_format", 6'h31, 8'h0B);
    cs_low();
    spi_bits(8'h31, 8);
    spi_bits(8'hF0, 5);
    cs_high();
    spi_read1("data_format_abort", 6'h31, 8'h0B);
    expect_byte("wrap_3f", 8'h00);
    expect_byte("wrap_00", 8'hE5);
    cs_low();
    spi_bits(8'hFF, 8);
    spi_bits(8'h00, 8);
    spi_bits(8'h00, 8);
    cs_high();

    // Asynchronous reset in the middle of a read
    push_sample(16'h0001, 16'h0002, 16'h0003);
    cs_low();
    spi_bits(8'h80, 8);
    spi_bits(8'h00, 2);
    check("pre_rst_sdo", {7'd0, spi_sdo}, 8'd1);
    check("pre_rst_dri", {7'd0, data_ready_int}, 8'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_sdo", {7'd0, spi_sdo}, 8'd0);
    check("mid_rst_sdo_oe", {7'd0, spi_sdo_oe}, 8'd0);
    check("mid_rst_sample_ready", {7'd0, sample_ready}, 8'd0);
    check("mid_rst_dri", {7'd0, data_ready_int}, 8'd0);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    spi_csn = 1'b1;
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(4);
    spi_read1("power_ctl_after_rst", 6'h2D, 8'h00);
    spi_read1("bank_after_rst", 6'h32, 8'h00);

    wait_clk(10);
    check("queue_drained", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
